multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle RV32I-subset control unit sequencing the shared ALU, memory, regfile and PC.
//  Moore FSM steps each instruction through fetch/decode/execute/writeback.
//  Includes the ALU decoder that produces the 3-bit ALU operation code.
//  Sits between the instruction register and the datapath muxes/enables.
// PARAMETERS
//  (none) - encodings fixed in riscv_ctrl_pkg
// PORTS
//  clk            in   1  single clock, rising edge
//  reset          in   1  asynchronous, active-high
//  opcode         in   7  instr[6:0] from instruction register
//  funct3         in   3  instr[14:12]
//  funct7b5       in   1  instr[30]
//  zero           in   1  ALU zero flag
//  pc_write       out  1  PC enable
//  adr_src        out  1  0=PC, 1=ALU result register to memory address
//  mem_write      out  1  data memory write enable
//  ir_write       out  1  instruction/old-PC register enable
//  result_src     out  2  00 ALUOut, 01 mem data, 10 ALU result
//  alu_src_a      out  2  00 PC, 01 old PC, 10 rs1
//  alu_src_b      out  2  00 rs2, 01 imm, 10 const 4
//  imm_src        out  2  00 I, 01 S, 10 B, 11 J
//  reg_write      out  1  regfile write enable
//  alu_control    out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  illegal_instr  out  1  sticky; set on undecodable instruction
// BEHAVIOUR
//  - States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT.
//  - Reset: state=FETCH, illegal_instr=0. While reset is high, pc_write, ir_write, mem_write, reg_write=0.
//  - FETCH: ir_write=1, adr_src=0, src_a=00, src_b=10, ADD, result_src=10, pc_write=1. Next: DECODE.
//  - DECODE: src_a=01, src_b=01, ADD (branch target into ALUOut).
//    lw/sw->MEMADR; R->EXECR; I-ALU->EXECI; beq->BEQ; jal->JAL; else HALT.
//  - MEMADR: src_a=10, src_b=01, ADD. lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: adr_src=1 ->MEMWB. MEMWB: result_src=01, reg_write=1 ->FETCH.
//  - MEMWRITE: adr_src=1, mem_write=1 ->FETCH.
//  - EXECR: src_a=10, src_b=00, alu_op=10 ->ALUWB.
//  - EXECI: src_a=10, src_b=01, alu_op=10 ->ALUWB.
//  - ALUWB: result_src=00, reg_write=1 ->FETCH.
//  - BEQ: src_a=10, src_b=00, SUB, result_src=00. pc_write=zero ->FETCH.
//  - JAL: src_a=01, src_b=10, ADD, result_src=00, pc_write=1 ->ALUWB.
//  - HALT: absorbing; all enables 0; illegal_instr=1 until reset.
//  - Output timing: outputs are combinational from state only; exception pc_write in BEQ = zero.
//    Latencies: lw 5, sw/R/I 4, beq 3, jal 4 cycles.
//  - imm_src: lw/I=00, sw=01, beq=10, jal=11. Decoded from opcode in every state; unknown opcode=00.
//  - ALU decoder (alu_op internal 2b): 00->ADD; 01->SUB; 10 decodes funct3:
//    000 = SUB if opcode[5]&funct7b5, else ADD; 110=OR; 111=AND; 010=SLT (if enabled).
//  - Illegal -> HALT from DECODE: unknown opcode, beq with funct3!=000, unsupported funct3 in R/I.
//    Also R-type with funct7b5=1 and funct3!=000.
//  - Reset mid-instruction: state and all enables revert to reset values immediately (async);
//    FETCH resumes on the first edge after release.
// CONFIGURATION
//  CTRL_SLT_EN defined:     funct3=010 in R/I decodes to alu_control=111 (SLT).
//  CTRL_SLT_EN not defined: funct3=010 is illegal -> HALT; alu_control never 111.
// STRUCTURE
//  - riscv_ctrl_pkg: state enum, opcode localparams (LW 0000011, SW 0100011, R 0110011,
//    I 0010011, BEQ 1100011, JAL 1101111), ALU code constants, alu_op encoding.
//  - Sub-module alu_decoder (combinational: alu_op, funct3, opcode[5], funct7b5 -> alu_control, illegal).
// TESTING
//  - Reset held 3 cycles, released -> enables 0 during reset; FETCH on 1st edge: ir_write=1, pc_write=1.
//  - add (R, funct3=000, f7b5=0) -> FETCH,DECODE,EXECR,ALUWB; EXECR alu_control=010; ALUWB reg_write=1.
//  - sub (R, funct7b5=1) -> EXECR alu_control=110.
//    andi/ori -> EXECI alu_control=000/001, alu_src_b=01.
//  - beq: zero=1 -> BEQ pc_write=1, alu_control=110. Repeat with zero=0 -> pc_write=0.
//    Both -> FETCH next.
//  - lw -> 5 states; MEMREAD adr_src=1; MEMWB result_src=01, reg_write=1.
//    sw -> MEMWRITE mem_write=1, imm_src=01.
//  - opcode 1111111 -> HALT, illegal_instr=1 held 10 cycles, enables 0.
//    slt: HALT without CTRL_SLT_EN; alu_control=111 with it. Async reset mid-MEMADR -> FETCH.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control unit: FSM states,
// opcodes, ALU operation codes and the internal alu_op selector.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps alu_op/funct3/opcode[5]/funct7b5 to the 3-bit ALU code and
// flags funct fields that are not decodable. SLT support is enabled by CTRL_SLT_EN.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    logic       w_sub;
    logic [2:0] w_funct_ctrl;

    // funct7b5 only selects SUB for register-register ops; in I-type it is immediate data.
    assign w_sub = i_op5 & i_funct7b5;

    // o_illegal describes the funct fields themselves, independent of alu_op,
    // so the FSM can reject an instruction while still in DECODE.
    always_comb begin
        w_funct_ctrl = ALU_ADD;
        o_illegal    = 1'b0;
        case (i_funct3)
            3'b000: w_funct_ctrl = w_sub ? ALU_SUB : ALU_ADD;
            3'b110: begin
                w_funct_ctrl = ALU_OR;
                o_illegal    = w_sub;
            end
            3'b111: begin
                w_funct_ctrl = ALU_AND;
                o_illegal    = w_sub;
            end
`ifdef CTRL_SLT_EN
            3'b010: begin
                w_funct_ctrl = ALU_SLT;
                o_illegal    = w_sub;
            end
`endif
            default: o_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB:   o_alu_control = ALU_SUB;
            ALUOP_FUNCT: o_alu_control = w_funct_ctrl;
            default:     o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control unit: Moore FSM driving the shared datapath.
// Define CTRL_SLT_EN to accept slt/slti (decoded in alu_decoder).
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t  r_state;
    state_t  w_next;
    alu_op_t w_alu_op;
    logic    w_funct_illegal;
    logic    r_illegal;
    logic    w_pc_write;
    logic    w_mem_write;
    logic    w_ir_write;
    logic    w_reg_write;

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (opcode[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (alu_control),
        .o_illegal     (w_funct_illegal)
    );

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_next == S_HALT)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_next      = r_state;
        w_alu_op    = ALUOP_ADD;
        w_pc_write  = 1'b0;
        adr_src     = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        w_reg_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                w_next     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = w_funct_illegal ? S_HALT : S_EXECR;
                    OP_I:         w_next = w_funct_illegal ? S_HALT : S_EXECI;
                    OP_BEQ:       w_next = (funct3 == 3'b000) ? S_BEQ : S_HALT;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_next    = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                w_next  = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                w_alu_op  = ALUOP_FUNCT;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = zero;
                w_next     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                w_pc_write = 1'b1;
                w_next     = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // State sits in FETCH during reset, so its enables must be masked by reset itself.
    assign pc_write      = w_pc_write  & ~reset;
    assign ir_write      = w_ir_write  & ~reset;
    assign mem_write     = w_mem_write & ~reset;
    assign reg_write     = w_reg_write & ~reset;
    assign illegal_instr = r_illegal;

    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; expected outputs are a
// hand-written per-state table. Build with CTRL_SLT_EN to exercise SLT decode.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [2:0] alu_control;
    logic       illegal_instr;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    typedef enum {
        E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE,
        E_EXECR, E_EXECI, E_ALUWB, E_BEQ, E_JAL
    } exp_st_t;

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b, reg_write, alu_control}
    logic [13:0] got_vec;
    logic [3:0]  got_en;
    assign got_vec = {pc_write, adr_src, mem_write, ir_write, result_src,
                      alu_src_a, alu_src_b, reg_write, alu_control};
    assign got_en  = {pc_write, ir_write, mem_write, reg_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] exp_vec(input exp_st_t st, input logic [2:0] alu, input logic z);
        case (st)
            E_FETCH:    return {1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 3'b010};
            E_DECODE:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, 3'b010};
            E_MEMADR:   return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 3'b010};
            E_MEMREAD:  return {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010};
            E_MEMWB:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 3'b010};
            E_MEMWRITE: return {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 3'b010};
            E_EXECR:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, alu};
            E_EXECI:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, alu};
            E_ALUWB:    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 3'b010};
            E_BEQ:      return {z,    1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 3'b110};
            E_JAL:      return {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 3'b010};
            default:    return 14'h0;
        endcase
    endfunction

    task automatic exp_st(input string tag, input exp_st_t st, input logic [2:0] alu);
        check(tag, 32'(got_vec), 32'(exp_vec(st, alu, zero)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_rst_en"}, 32'(got_en), 32'h0);
        check({tag, "_rst_ill"}, 32'(illegal_instr), 32'h0);
        repeat (3) step();
        check({tag, "_rst_hold_en"}, 32'(got_en), 32'h0);
        reset = 1'b0;
        #1;
    endtask

    // R/I ALU instruction: FETCH, DECODE, EXECR/EXECI, ALUWB, back to FETCH.
    task automatic do_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [2:0] alu);
        set_instr(op, f3, f7);
        exp_st({tag, "_fetch"}, E_FETCH, 3'b010);
        step();
        exp_st({tag, "_decode"}, E_DECODE, 3'b010);
        check({tag, "_imm"}, 32'(imm_src), 32'h0);
        step();
        exp_st({tag, "_exec"}, (op == T_R) ? E_EXECR : E_EXECI, alu);
        step();
        exp_st({tag, "_aluwb"}, E_ALUWB, 3'b010);
        step();
    endtask

    // Any instruction expected to be rejected in DECODE.
    task automatic do_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input int hold);
        set_instr(op, f3, f7);
        exp_st({tag, "_fetch"}, E_FETCH, 3'b010);
        step();
        check({tag, "_ill_pre"}, 32'(illegal_instr), 32'h0);
        step();
        for (int i = 0; i < hold; i++) begin
            check($sformatf("%s_halt_ill%0d", tag, i), 32'(illegal_instr), 32'h1);
            check($sformatf("%s_halt_en%0d", tag, i), 32'(got_en), 32'h0);
            step();
        end
        do_reset({tag, "_recover"});
    endtask

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        set_instr(7'h00, 3'b000, 1'b0);
        #1;
        do_reset("init");
        exp_st("init_fetch", E_FETCH, 3'b010);

        do_alu("add",  T_R, 3'b000, 1'b0, 3'b010);
        do_alu("sub",  T_R, 3'b000, 1'b1, 3'b110);
        do_alu("and",  T_R, 3'b111, 1'b0, 3'b000);
        do_alu("or",   T_R, 3'b110, 1'b0, 3'b001);
        do_alu("andi", T_I, 3'b111, 1'b0, 3'b000);
        do_alu("ori",  T_I, 3'b110, 1'b0, 3'b001);
        do_alu("addi", T_I, 3'b000, 1'b1, 3'b010);

        for (int z = 1; z >= 0; z--) begin
            set_instr(T_BEQ, 3'b000, 1'b0);
            zero = z[0];
            exp_st($sformatf("beq%0d_fetch", z), E_FETCH, 3'b010);
            step();
            exp_st($sformatf("beq%0d_decode", z), E_DECODE, 3'b010);
            check($sformatf("beq%0d_imm", z), 32'(imm_src), 32'h2);
            step();
            exp_st($sformatf("beq%0d_beq", z), E_BEQ, 3'b110);
            step();
            exp_st($sformatf("beq%0d_next", z), E_FETCH, 3'b010);
        end
        zero = 1'b0;

        set_instr(T_LW, 3'b010, 1'b0);
        step();
        exp_st("lw_decode", E_DECODE, 3'b010);
        check("lw_imm", 32'(imm_src), 32'h0);
        step();
        exp_st("lw_memadr", E_MEMADR, 3'b010);
        step();
        exp_st("lw_memread", E_MEMREAD, 3'b010);
        step();
        exp_st("lw_memwb", E_MEMWB, 3'b010);
        step();
        exp_st("lw_next", E_FETCH, 3'b010);

        set_instr(T_SW, 3'b010, 1'b0);
        step();
        exp_st("sw_decode", E_DECODE, 3'b010);
        check("sw_imm", 32'(imm_src), 32'h1);
        step();
        exp_st("sw_memadr", E_MEMADR, 3'b010);
        step();
        exp_st("sw_memwrite", E_MEMWRITE, 3'b010);
        step();
        exp_st("sw_next", E_FETCH, 3'b010);

        set_instr(T_JAL, 3'b000, 1'b0);
        step();
        exp_st("jal_decode", E_DECODE, 3'b010);
        check("jal_imm", 32'(imm_src), 32'h3);
        step();
        exp_st("jal_jal", E_JAL, 3'b010);
        step();
        exp_st("jal_aluwb", E_ALUWB, 3'b010);
        step();
        exp_st("jal_next", E_FETCH, 3'b010);

        // Asynchronous reset while in MEMADR.
        set_instr(T_LW, 3'b000, 1'b0);
        step();
        step();
        exp_st("arst_memadr", E_MEMADR, 3'b010);
        #2;
        reset = 1'b1;
        #1;
        check("arst_en", 32'(got_en), 32'h0);
        check("arst_srcs", 32'({alu_src_a, alu_src_b}), 32'h2);
        step();
        reset = 1'b0;
        #1;
        exp_st("arst_fetch", E_FETCH, 3'b010);
        step();
        exp_st("arst_decode", E_DECODE, 3'b010);
        step();
        exp_st("arst_memadr2", E_MEMADR, 3'b010);
        do_reset("arst_clean");

`ifdef CTRL_SLT_EN
        do_alu("slt",  T_R, 3'b010, 1'b0, 3'b111);
        do_alu("slti", T_I, 3'b010, 1'b0, 3'b111);
`else
        do_illegal("slt", T_R, 3'b010, 1'b0, 2);
`endif
        do_illegal("badop",   7'b1111111, 3'b000, 1'b0, 10);
        do_illegal("beqf3",   T_BEQ,      3'b001, 1'b0, 2);
        do_illegal("rf7or",   T_R,        3'b110, 1'b1, 2);
        do_illegal("rf3",     T_R,        3'b001, 1'b0, 2);
        do_illegal("if3",     T_I,        3'b100, 1'b0, 2);

        exp_st("final_fetch", E_FETCH, 3'b010);
        do_alu("final_add", T_R, 3'b000, 1'b0, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
